// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared 1024x768 timing constants for the VGA horizontal and vertical stages
package vga_timing_pkg;

    localparam int   H_COUNTER_SIZE_DEF = 11;
    localparam int   V_COUNTER_SIZE_DEF = 10;
    localparam int   H_LAST_DEF         = 1327;
    localparam int   H_VISIBLE_DEF      = 1024;
    localparam int   V_LAST_DEF         = 805;
    localparam int   V_SYNC_LINES_DEF   = 6;
    localparam int   V_ACTIVE_START_DEF = 35;
    localparam int   V_VISIBLE_DEF      = 768;
    localparam logic V_SYNC_ACTIVE_DEF  = 1'b0;

endpackage

// File: rtl/vga_line_counter.sv
// rtl/vga_line_counter.sv - frame line counter with wrap at LAST and a look-ahead next-value output
module vga_line_counter #(
    parameter int WIDTH = 10,
    parameter int LAST  = 805
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_advance,
    output logic [WIDTH-1:0] o_count,
    output logic [WIDTH-1:0] o_next,
    output logic             o_wrap
);

    localparam logic [WIDTH-1:0] LP_LAST = WIDTH'(LAST);

    logic [WIDTH-1:0] r_count;
    logic             w_at_last;

    assign w_at_last = (r_count == LP_LAST);
    assign o_wrap    = i_advance && w_at_last;
    assign o_next    = !i_advance ? r_count
                     : (w_at_last ? '0 : r_count + 1'b1);
    assign o_count   = r_count;

    // Resetting to LAST makes the first advance after reset open a fresh frame at line 0.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= LP_LAST;
        end else begin
            r_count <= o_next;
        end
    end

endmodule

// File: rtl/vga_v_timing_generator.sv
// rtl/vga_v_timing_generator.sv - vertical VGA timing: line count, v_sync, display enable, frame pulse, error flag
module vga_v_timing_generator
    import vga_timing_pkg::*;
#(
    parameter int   H_COUNTER_SIZE = H_COUNTER_SIZE_DEF,
    parameter int   V_COUNTER_SIZE = V_COUNTER_SIZE_DEF,
    parameter int   H_LAST         = H_LAST_DEF,
    parameter int   H_VISIBLE      = H_VISIBLE_DEF,
    parameter int   V_LAST         = V_LAST_DEF,
    parameter int   V_SYNC_LINES   = V_SYNC_LINES_DEF,
    parameter int   V_ACTIVE_START = V_ACTIVE_START_DEF,
    parameter int   V_VISIBLE      = V_VISIBLE_DEF,
    parameter logic V_SYNC_ACTIVE  = V_SYNC_ACTIVE_DEF
) (
    input  logic                      control_clock,
    input  logic                      reset_n,
    input  logic [H_COUNTER_SIZE-1:0] h_counter,
    output logic                      v_sync,
    output logic [V_COUNTER_SIZE-1:0] v_counter,
    output logic                      video_on,
    output logic                      frame_start,
    output logic                      timing_error
);

    localparam logic [H_COUNTER_SIZE-1:0] LP_H_LAST     = H_COUNTER_SIZE'(H_LAST);
    localparam logic [H_COUNTER_SIZE-1:0] LP_H_VISIBLE  = H_COUNTER_SIZE'(H_VISIBLE);
    localparam logic [V_COUNTER_SIZE-1:0] LP_SYNC_LINES = V_COUNTER_SIZE'(V_SYNC_LINES);
    localparam logic [V_COUNTER_SIZE-1:0] LP_ACT_FIRST  = V_COUNTER_SIZE'(V_ACTIVE_START);
    localparam logic [V_COUNTER_SIZE-1:0] LP_ACT_LAST   = V_COUNTER_SIZE'(V_ACTIVE_START + V_VISIBLE - 1);

    logic                      r_h_last_q;
    logic                      r_v_sync;
    logic                      r_video_on;
    logic                      r_frame_start;
    logic                      r_timing_error;

    logic                      w_at_h_last;
    logic                      w_h_over;
    logic                      w_advance;
    logic                      w_h_visible;
    logic                      w_v_visible;
    logic                      w_wrap;
    logic [V_COUNTER_SIZE-1:0] w_v_count;
    logic [V_COUNTER_SIZE-1:0] w_v_next;

    // A held H_LAST must count as one line end, so only the first cycle at H_LAST advances.
    assign w_at_h_last = (h_counter == LP_H_LAST);
    assign w_h_over    = (h_counter > LP_H_LAST);
    assign w_advance   = w_at_h_last && !r_h_last_q;

    assign w_h_visible = (h_counter < LP_H_VISIBLE);
    assign w_v_visible = (w_v_count >= LP_ACT_FIRST) && (w_v_count <= LP_ACT_LAST);

    vga_line_counter #(
        .WIDTH (V_COUNTER_SIZE),
        .LAST  (V_LAST)
    ) u_line_counter (
        .i_clk     (control_clock),
        .i_rst_n   (reset_n),
        .i_advance (w_advance),
        .o_count   (w_v_count),
        .o_next    (w_v_next),
        .o_wrap    (w_wrap)
    );

    // v_sync is decoded from the upcoming line so it switches on the same edge as v_counter.
    always_ff @(posedge control_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_h_last_q     <= 1'b0;
            r_v_sync       <= ~V_SYNC_ACTIVE;
            r_video_on     <= 1'b0;
            r_frame_start  <= 1'b0;
            r_timing_error <= 1'b0;
        end else begin
            r_h_last_q     <= w_at_h_last;
            r_v_sync       <= (w_v_next < LP_SYNC_LINES) ? V_SYNC_ACTIVE : ~V_SYNC_ACTIVE;
            r_video_on     <= w_h_visible && w_v_visible;
            r_frame_start  <= w_wrap;
            r_timing_error <= r_timing_error | w_h_over;
        end
    end

    assign v_sync       = r_v_sync;
    assign v_counter    = w_v_count;
    assign video_on     = r_video_on;
    assign frame_start  = r_frame_start;
    assign timing_error = r_timing_error;

endmodule

// File: tb/tb_vga_v_timing_generator.sv
// tb/tb_vga_v_timing_generator.sv - self-checking bench for vga_v_timing_generator
module tb_vga_v_timing_generator;

    typedef struct {
        logic [10:0] h;
        logic [9:0]  vc;
        logic        vs;
        logic        von;
        logic        fs;
        logic        err;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [10:0] h_counter;
    logic        v_sync;
    logic [9:0]  v_counter;
    logic        video_on;
    logic        frame_start;
    logic        timing_error;

    int n_vec;
    int n_bad;

    int m_line;
    bit m_prev_last;
    bit m_err;
    bit m_vs;
    bit m_von;
    bit m_fs;

    vec_t tbl [9];

    vga_v_timing_generator dut (
        .control_clock (clk),
        .reset_n       (rst_n),
        .h_counter     (h_counter),
        .v_sync        (v_sync),
        .v_counter     (v_counter),
        .video_on      (video_on),
        .frame_start   (frame_start),
        .timing_error  (timing_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_reset();
        m_line      = 805;
        m_prev_last = 1'b0;
        m_err       = 1'b0;
        m_vs        = 1'b1;
        m_von       = 1'b0;
        m_fs        = 1'b0;
    endtask

    task automatic model_step(input int h);
        bit adv;
        m_von = (h < 1024) && (m_line >= 35) && (m_line < 35 + 768);
        adv   = (h == 1327) && !m_prev_last;
        m_fs  = adv && (m_line == 805);
        if (adv) m_line = (m_line + 1) % 806;
        m_vs  = (m_line < 6) ? 1'b0 : 1'b1;
        if (h > 1327) m_err = 1'b1;
        m_prev_last = (h == 1327);
    endtask

    task automatic chk(input string name, input int evc, input bit evs,
                       input bit evon, input bit efs, input bit eerr);
        n_vec++;
        if (v_counter !== 10'(evc) || v_sync !== evs || video_on !== evon ||
            frame_start !== efs || timing_error !== eerr) begin
            n_bad++;
            $display("FAIL %s: got vc=%0d vs=%b von=%b fs=%b err=%b, want vc=%0d vs=%b von=%b fs=%b err=%b",
                     name, v_counter, v_sync, video_on, frame_start, timing_error,
                     evc, evs, evon, efs, eerr);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic tick(input int h);
        h_counter = 11'(h);
        @(posedge clk);
        #1;
        model_step(h);
        chk("model", m_line, m_vs, m_von, m_fs, m_err);
    endtask

    task automatic goto_line(input int line);
        int guard;
        guard = 0;
        while (m_line != line && guard < 2000) begin
            tick(0);
            tick(1327);
            guard++;
        end
        chk_int("goto_line", m_line, line);
    endtask

    initial begin
        int fs_cnt;
        int sync_low;
        int r;
        int hv;

        n_vec = 0;
        n_bad = 0;

        tbl[0] = '{11'd1023, 10'd35, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{11'd1024, 10'd35, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{11'd1327, 10'd36, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{11'd1327, 10'd36, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{11'd1327, 10'd36, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{11'd0,    10'd36, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{11'd1500, 10'd36, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[7] = '{11'd1327, 10'd37, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[8] = '{11'd500,  10'd37, 1'b1, 1'b1, 1'b0, 1'b1};

        rst_n     = 1'b0;
        h_counter = 11'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_values", 805, 1'b1, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // First line after reset wraps to line 0 with a one-cycle frame_start.
        for (int h = 0; h < 1327; h++) tick(h);
        tick(1327);
        chk("first_wrap", 0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(0);
        chk("first_wrap_pulse_end", 0, 1'b0, 1'b1 & 1'b0, 1'b0, 1'b0);
        for (int h = 1; h <= 1327; h++) tick(h);
        chk("second_line", 1, 1'b0, 1'b0, 1'b0, 1'b0);

        fs_cnt   = 0;
        sync_low = 0;
        for (int l = 0; l < 806; l++) begin
            tick(0);
            tick(1327);
            fs_cnt   += int'(frame_start);
            sync_low += int'(!v_sync);
        end
        chk_int("frame_start_per_frame", fs_cnt, 1);
        chk_int("vsync_low_lines", sync_low, 6);
        chk_int("frame_returns_to_line1", int'(v_counter), 1);

        goto_line(34);
        tick(500);
        chk("line34_dark", 34, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(1327);
        chk("enter_line35", 35, 1'b1, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 9; i++) begin
            tick(int'(tbl[i].h));
            chk($sformatf("table[%0d]", i), int'(tbl[i].vc), tbl[i].vs,
                tbl[i].von, tbl[i].fs, tbl[i].err);
        end

        goto_line(802);
        tick(100);
        chk("line802_lit", 802, 1'b1, 1'b1, 1'b0, 1'b1);
        tick(1327);
        tick(100);
        chk("line803_dark", 803, 1'b1, 1'b0, 1'b0, 1'b1);

        goto_line(400);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_reset", 805, 1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("reset_held", 805, 1'b1, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick(0);
        tick(1327);
        chk("post_reset_wrap", 0, 1'b0, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 30)      hv = 1327;
            else if (r < 31) hv = int'($urandom_range(1328, 2047));
            else             hv = int'($urandom_range(0, 1327));
            tick(hv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
